// File: rtl/mem_access_master.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_master
// Brief    : Single-outstanding load/store master. Accepts one byte/half/
//            word/double request, checks natural alignment, performs one
//            read or one masked write on a 64-bit memory port, and returns
//            an extended load result or a misalignment flag.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_master (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_misalign,
  output logic        mem_rd_en,
  output logic [63:0] mem_rd_addr,
  input  logic [63:0] mem_rd_data,
  output logic        mem_we_en,
  output logic [63:0] mem_we_addr,
  output logic [63:0] mem_we_data,
  output logic [7:0]  mem_we_mask
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state_q,         state_d;
  logic        req_ready_q,     req_ready_d;
  logic [2:0]  offset_q,        offset_d;
  logic [1:0]  size_q,          size_d;
  logic        unsigned_q,      unsigned_d;
  logic        resp_valid_q,    resp_valid_d;
  logic [63:0] resp_rdata_q,    resp_rdata_d;
  logic        resp_misalign_q, resp_misalign_d;
  logic        mem_rd_en_q,     mem_rd_en_d;
  logic [63:0] mem_rd_addr_q,   mem_rd_addr_d;
  logic        mem_we_en_q,     mem_we_en_d;
  logic [63:0] mem_we_addr_q,   mem_we_addr_d;
  logic [63:0] mem_we_data_q,   mem_we_data_d;
  logic [7:0]  mem_we_mask_q,   mem_we_mask_d;

  logic        req_misaligned;
  logic [7:0]  req_mask_base;
  logic [63:0] rd_shifted;
  logic [63:0] load_ext;

  // Alignment check and byte-enable pattern for the request being offered.
  always_comb begin
    req_misaligned = 1'b0;
    req_mask_base  = 8'h01;
    case (req_size)
      2'd0: begin req_misaligned = 1'b0;                 req_mask_base = 8'h01; end
      2'd1: begin req_misaligned = req_addr[0];          req_mask_base = 8'h03; end
      2'd2: begin req_misaligned = |req_addr[1:0];       req_mask_base = 8'h0F; end
      default: begin req_misaligned = |req_addr[2:0];    req_mask_base = 8'hFF; end
    endcase
  end

  // Right-justify the addressed bytes of the read word and extend to 64 bits.
  always_comb begin
    rd_shifted = mem_rd_data >> {offset_q, 3'b000};
    case (size_q)
      2'd0: load_ext = unsigned_q ? {56'd0, rd_shifted[7:0]}
                                  : {{56{rd_shifted[7]}}, rd_shifted[7:0]};
      2'd1: load_ext = unsigned_q ? {48'd0, rd_shifted[15:0]}
                                  : {{48{rd_shifted[15]}}, rd_shifted[15:0]};
      2'd2: load_ext = unsigned_q ? {32'd0, rd_shifted[31:0]}
                                  : {{32{rd_shifted[31]}}, rd_shifted[31:0]};
      default: load_ext = rd_shifted;
    endcase
  end

  // Next-state and next-output logic; enables and write data default low so
  // each memory strobe lasts exactly one cycle.
  always_comb begin
    state_d         = state_q;
    req_ready_d     = req_ready_q;
    offset_d        = offset_q;
    size_d          = size_q;
    unsigned_d      = unsigned_q;
    resp_valid_d    = resp_valid_q;
    resp_rdata_d    = resp_rdata_q;
    resp_misalign_d = resp_misalign_q;
    mem_rd_en_d     = 1'b0;
    mem_rd_addr_d   = mem_rd_addr_q;
    mem_we_en_d     = 1'b0;
    mem_we_addr_d   = mem_we_addr_q;
    mem_we_data_d   = 64'd0;
    mem_we_mask_d   = 8'd0;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          offset_d    = req_addr[2:0];
          size_d      = req_size;
          unsigned_d  = req_unsigned;
          if (req_misaligned) begin
            state_d         = RESP;
            resp_valid_d    = 1'b1;
            resp_rdata_d    = 64'd0;
            resp_misalign_d = 1'b1;
          end else if (req_wen) begin
            state_d       = WRITE;
            mem_we_en_d   = 1'b1;
            mem_we_addr_d = {req_addr[63:3], 3'b000};
            mem_we_data_d = req_wdata << {req_addr[2:0], 3'b000};
            mem_we_mask_d = req_mask_base << req_addr[2:0];
          end else begin
            state_d       = READ;
            mem_rd_en_d   = 1'b1;
            mem_rd_addr_d = {req_addr[63:3], 3'b000};
          end
        end
      end
      READ: begin
        state_d         = RESP;
        resp_valid_d    = 1'b1;
        resp_rdata_d    = load_ext;
        resp_misalign_d = 1'b0;
      end
      WRITE: begin
        state_d         = RESP;
        resp_valid_d    = 1'b1;
        resp_rdata_d    = 64'd0;
        resp_misalign_d = 1'b0;
      end
      default: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
    endcase
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      req_ready_q     <= 1'b0;
      offset_q        <= 3'd0;
      size_q          <= 2'd0;
      unsigned_q      <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= 64'd0;
      resp_misalign_q <= 1'b0;
      mem_rd_en_q     <= 1'b0;
      mem_rd_addr_q   <= 64'd0;
      mem_we_en_q     <= 1'b0;
      mem_we_addr_q   <= 64'd0;
      mem_we_data_q   <= 64'd0;
      mem_we_mask_q   <= 8'd0;
    end else begin
      state_q         <= state_d;
      req_ready_q     <= req_ready_d;
      offset_q        <= offset_d;
      size_q          <= size_d;
      unsigned_q      <= unsigned_d;
      resp_valid_q    <= resp_valid_d;
      resp_rdata_q    <= resp_rdata_d;
      resp_misalign_q <= resp_misalign_d;
      mem_rd_en_q     <= mem_rd_en_d;
      mem_rd_addr_q   <= mem_rd_addr_d;
      mem_we_en_q     <= mem_we_en_d;
      mem_we_addr_q   <= mem_we_addr_d;
      mem_we_data_q   <= mem_we_data_d;
      mem_we_mask_q   <= mem_we_mask_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_misalign = resp_misalign_q;
  assign mem_rd_en     = mem_rd_en_q;
  assign mem_rd_addr   = mem_rd_addr_q;
  assign mem_we_en     = mem_we_en_q;
  assign mem_we_addr   = mem_we_addr_q;
  assign mem_we_data   = mem_we_data_q;
  assign mem_we_mask   = mem_we_mask_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_master
// Brief    : Self-checking bench for mem_access_master. Expected responses
//            are queued when a request is driven and popped on response.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_master;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_misalign;
  logic [63:0] resp_rdata;
  logic        mem_rd_en, mem_we_en;
  logic [63:0] mem_rd_addr, mem_rd_data, mem_we_addr, mem_we_data;
  logic [7:0]  mem_we_mask;

  typedef struct {
    logic [63:0] rdata;
    logic        misalign;
  } exp_t;
  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int rd_cnt = 0;
  int we_cnt = 0;
  int both_hi = 0;

  always #5 clock = ~clock;

  mem_access_master dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_misalign(resp_misalign),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_we_en(mem_we_en), .mem_we_addr(mem_we_addr), .mem_we_data(mem_we_data),
    .mem_we_mask(mem_we_mask)
  );

  // Strobe monitor, sampled mid-cycle.
  always @(negedge clock) begin
    if (mem_rd_en === 1'b1) rd_cnt++;
    if (mem_we_en === 1'b1) we_cnt++;
    if (mem_rd_en === 1'b1 && mem_we_en === 1'b1) both_hi++;
  end

  // Reference load: gather bytes one at a time, then extend.
  function automatic logic [63:0] model_load(input logic [63:0] word, input int off,
                                             input int sz, input logic uns);
    logic [63:0] r = 64'd0;
    int n = 1 << sz;
    for (int i = 0; i < n; i++) r[i*8 +: 8] = word[(off+i)*8 +: 8];
    if (!uns && n < 8 && r[n*8-1]) for (int i = n; i < 8; i++) r[i*8 +: 8] = 8'hFF;
    return r;
  endfunction

  function automatic logic [7:0] model_mask(input int off, input int sz);
    logic [7:0] m = 8'd0;
    for (int i = 0; i < (1 << sz); i++) m[off+i] = 1'b1;
    return m;
  endfunction

  // Present one request at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [1:0] sz, input logic uns);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
    req_size = sz; req_unsigned = uns;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  // Wait (bounded) for resp_valid; lat counts negedges after issue returned.
  task automatic wait_resp(output logic [63:0] rd, output logic mis, output int lat,
                           output bit to);
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    to  = (resp_valid !== 1'b1);
    rd  = resp_rdata;
    mis = resp_misalign;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; resp_ready = 1'b1; req_valid = 1'b0; req_wen = 1'b0;
    req_addr = '0; req_wdata = '0; req_size = '0; req_unsigned = 1'b0; mem_rd_data = '0;
    repeat (2) @(negedge clock);
    n_vec++;
    if ({req_ready, resp_valid, resp_misalign, mem_rd_en, mem_we_en} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got rdy/rv/mis/rd/we=%b required 00000",
               {req_ready, resp_valid, resp_misalign, mem_rd_en, mem_we_en});
    end
    n_vec++;
    if ({resp_rdata, mem_we_data, mem_we_mask, mem_rd_addr, mem_we_addr} !== '0) begin
      n_err++;
      $display("FAIL reset_data: rdata=%h wdata=%h mask=%h raddr=%h waddr=%h required all 0",
               resp_rdata, mem_we_data, mem_we_mask, mem_rd_addr, mem_we_addr);
    end
    reset_n = 1'b1;
    @(negedge clock);
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_ready: got %b required 1", req_ready);
    end
  endtask

  task automatic test_load_d();
    logic [63:0] rd; logic mis; int lat; bit to; int rd0; exp_t e;
    mem_rd_data = 64'h1122334455667788;
    rd0 = rd_cnt;
    exp_q.push_back('{rdata: 64'h1122334455667788, misalign: 1'b0});
    issue(1'b0, 64'h80000008, 64'd0, 2'd3, 1'b0);
    n_vec++;
    if (mem_rd_en !== 1'b1 || mem_rd_addr !== 64'h80000008) begin
      n_err++;
      $display("FAIL load_d_strobe: en=%b addr=%h required 1 80000008", mem_rd_en, mem_rd_addr);
    end
    wait_resp(rd, mis, lat, to);
    e = exp_q.pop_front();
    n_vec++;
    // lat 1 here means resp_valid appears two cycles after the accept cycle.
    if (to || lat != 1 || rd !== e.rdata || mis !== e.misalign) begin
      n_err++;
      $display("FAIL load_d_resp: to=%0d lat=%0d rdata=%h mis=%b required 0 1 %h %b",
               to, lat, rd, mis, e.rdata, e.misalign);
    end
    @(negedge clock);
    n_vec++;
    if (rd_cnt - rd0 != 1 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL load_d_after: pulses=%0d rv=%b rdy=%b required 1 0 1",
               rd_cnt - rd0, resp_valid, req_ready);
    end
  endtask

  task automatic test_load_byte();
    logic [63:0] rd; logic mis; int lat; bit to; exp_t e;
    mem_rd_data = 64'h00000000_80000000;
    for (int u = 0; u < 2; u++) begin
      exp_q.push_back('{rdata: (u == 0) ? 64'hFFFFFFFFFFFFFF80 : 64'h0000000000000080,
                        misalign: 1'b0});
      issue(1'b0, 64'h80000003, 64'd0, 2'd0, u[0]);
      wait_resp(rd, mis, lat, to);
      e = exp_q.pop_front();
      n_vec++;
      if (to || rd !== e.rdata || mis !== e.misalign) begin
        n_err++;
        $display("FAIL load_byte_uns%0d: to=%0d rdata=%h mis=%b required 0 %h %b",
                 u, to, rd, mis, e.rdata, e.misalign);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_store_half();
    logic [63:0] rd; logic mis; int lat; bit to; exp_t e;
    exp_q.push_back('{rdata: 64'd0, misalign: 1'b0});
    issue(1'b1, 64'h80000006, 64'hABCD, 2'd1, 1'b0);
    n_vec++;
    if (mem_we_en !== 1'b1 || mem_we_addr !== 64'h80000000 ||
        mem_we_data !== 64'hABCD000000000000 || mem_we_mask !== 8'hC0 || mem_rd_en !== 1'b0) begin
      n_err++;
      $display("FAIL store_h_write: en=%b addr=%h data=%h mask=%h rd=%b required 1 80000000 abcd000000000000 c0 0",
               mem_we_en, mem_we_addr, mem_we_data, mem_we_mask, mem_rd_en);
    end
    wait_resp(rd, mis, lat, to);
    e = exp_q.pop_front();
    n_vec++;
    if (to || lat != 1 || rd !== e.rdata || mis !== e.misalign) begin
      n_err++;
      $display("FAIL store_h_resp: to=%0d lat=%0d rdata=%h mis=%b required 0 1 %h %b",
               to, lat, rd, mis, e.rdata, e.misalign);
    end
    n_vec++;
    if (mem_we_en !== 1'b0 || mem_we_data !== 64'd0 || mem_we_mask !== 8'd0) begin
      n_err++;
      $display("FAIL store_h_idle_bus: en=%b data=%h mask=%h required 0 0 0",
               mem_we_en, mem_we_data, mem_we_mask);
    end
    @(negedge clock);
  endtask

  task automatic test_misaligned();
    logic [63:0] rd; logic mis; int lat; bit to; int rd0; exp_t e;
    rd0 = rd_cnt;
    exp_q.push_back('{rdata: 64'd0, misalign: 1'b1});
    issue(1'b0, 64'h80000002, 64'd0, 2'd2, 1'b0);
    wait_resp(rd, mis, lat, to);
    e = exp_q.pop_front();
    n_vec++;
    // lat 0: response visible one cycle after the accept cycle.
    if (to || lat != 0 || rd !== e.rdata || mis !== e.misalign) begin
      n_err++;
      $display("FAIL misalign_resp: to=%0d lat=%0d rdata=%h mis=%b required 0 0 %h %b",
               to, lat, rd, mis, e.rdata, e.misalign);
    end
    @(negedge clock);
    n_vec++;
    if (rd_cnt != rd0) begin
      n_err++;
      $display("FAIL misalign_no_read: pulses=%0d required 0", rd_cnt - rd0);
    end
  endtask

  task automatic test_stall();
    logic [63:0] rd; logic mis; int lat; bit to; int rd0, we0; exp_t e;
    resp_ready = 1'b0;
    mem_rd_data = 64'hCAFEF00D_DEADBEEF;
    exp_q.push_back('{rdata: 64'hFFFFFFFFDEADBEEF, misalign: 1'b0});
    issue(1'b0, 64'h80000010, 64'd0, 2'd2, 1'b0);
    wait_resp(rd, mis, lat, to);
    e = exp_q.pop_front();
    n_vec++;
    if (to || rd !== e.rdata || mis !== e.misalign) begin
      n_err++;
      $display("FAIL stall_resp: to=%0d rdata=%h mis=%b required 0 %h %b", to, rd, mis, e.rdata, e.misalign);
    end
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h80000020; req_size = 2'd3; req_unsigned = 1'b0;
    rd0 = rd_cnt; we0 = we_cnt;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      n_vec++;
      if (resp_valid !== 1'b1 || resp_rdata !== e.rdata || resp_misalign !== 1'b0 ||
          req_ready !== 1'b0 || mem_rd_en !== 1'b0 || mem_we_en !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold_c%0d: rv=%b rdata=%h rdy=%b rd=%b we=%b required 1 %h 0 0 0",
                 c, resp_valid, resp_rdata, req_ready, mem_rd_en, mem_we_en, e.rdata);
      end
    end
    n_vec++;
    if (rd_cnt != rd0 || we_cnt != we0) begin
      n_err++;
      $display("FAIL stall_no_mem: rd=%0d we=%0d required 0 0", rd_cnt - rd0, we_cnt - we0);
    end
    resp_ready = 1'b1;
    @(negedge clock);
    n_vec++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL stall_release: rv=%b rdy=%b required 0 1", resp_valid, req_ready);
    end
    mem_rd_data = 64'h0102030405060708;
    exp_q.push_back('{rdata: 64'h0102030405060708, misalign: 1'b0});
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    n_vec++;
    if (mem_rd_en !== 1'b1 || mem_rd_addr !== 64'h80000020) begin
      n_err++;
      $display("FAIL stall_next_accept: en=%b addr=%h required 1 80000020", mem_rd_en, mem_rd_addr);
    end
    wait_resp(rd, mis, lat, to);
    e = exp_q.pop_front();
    n_vec++;
    if (to || rd !== e.rdata || mis !== e.misalign) begin
      n_err++;
      $display("FAIL stall_next_resp: to=%0d rdata=%h required 0 %h", to, rd, e.rdata);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid_write();
    int we0, rv_seen;
    we0 = we_cnt;
    rv_seen = 0;
    issue(1'b1, 64'h80000004, 64'h12345678, 2'd2, 1'b0);
    n_vec++;
    if (mem_we_en !== 1'b1) begin
      n_err++;
      $display("FAIL rst_write_entered: we=%b required 1", mem_we_en);
    end
    #1 reset_n = 1'b0;
    #1;
    n_vec++;
    if (mem_we_en !== 1'b0 || mem_we_mask !== 8'd0 || req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_write_drop: we=%b mask=%h rdy=%b required 0 00 0", mem_we_en, mem_we_mask, req_ready);
    end
    repeat (3) begin
      @(negedge clock);
      if (resp_valid !== 1'b0) rv_seen++;
    end
    reset_n = 1'b1;
    @(negedge clock);
    if (resp_valid !== 1'b0) rv_seen++;
    n_vec++;
    if (rv_seen != 0 || req_ready !== 1'b1 || we_cnt - we0 != 1) begin
      n_err++;
      $display("FAIL rst_write_after: rv_cycles=%0d rdy=%b we_pulses=%0d required 0 1 1",
               rv_seen, req_ready, we_cnt - we0);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] rd, addr, word, wdata; logic mis; int lat; bit to; exp_t e;
    int sz, off; logic wen, uns;
    for (int k = 0; k < 12; k++) begin
      sz    = int'($urandom_range(0, 3));
      off   = int'($urandom_range(0, 7)) & ~((1 << sz) - 1);
      wen   = 1'($urandom_range(0, 1));
      uns   = 1'($urandom_range(0, 1));
      addr  = 64'h80000000 + 64'($urandom_range(0, 255)) * 8 + 64'(off);
      word  = {$urandom, $urandom};
      wdata = {$urandom, $urandom};
      mem_rd_data = word;
      exp_q.push_back('{rdata: wen ? 64'd0 : model_load(word, off, sz, uns), misalign: 1'b0});
      issue(wen, addr, wdata, sz[1:0], uns);
      n_vec++;
      if (wen ? (mem_we_en !== 1'b1 || mem_rd_en !== 1'b0 || mem_we_addr !== {addr[63:3], 3'b000} ||
                 mem_we_mask !== model_mask(off, sz) || mem_we_data !== (wdata << (off * 8)))
              : (mem_rd_en !== 1'b1 || mem_we_en !== 1'b0 || mem_rd_addr !== {addr[63:3], 3'b000})) begin
        n_err++;
        $display("FAIL b2b_bus_%0d: wen=%b sz=%0d off=%0d rd=%b we=%b mask=%h data=%h required mask %h data %h",
                 k, wen, sz, off, mem_rd_en, mem_we_en, mem_we_mask, mem_we_data,
                 model_mask(off, sz), wdata << (off * 8));
      end
      wait_resp(rd, mis, lat, to);
      e = exp_q.pop_front();
      n_vec++;
      if (to || lat != 1 || rd !== e.rdata || mis !== e.misalign) begin
        n_err++;
        $display("FAIL b2b_resp_%0d: to=%0d lat=%0d rdata=%h mis=%b required 0 1 %h %b",
                 k, to, lat, rd, mis, e.rdata, e.misalign);
      end
      @(negedge clock);
    end
  endtask

  initial begin
    test_reset();
    test_load_d();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_stall();
    test_reset_mid_write();
    test_back_to_back();
    n_vec++;
    if (both_hi != 0) begin
      n_err++;
      $display("FAIL rd_we_exclusive: overlap cycles=%0d required 0", both_hi);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
